// File: rtl/layer_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_mac_sequencer
// Brief    : Counts per-input acks for each neuron of a fully connected layer,
//            fires the MAC unit under backpressure and flags end of layer.
// Revision : 1.0 - initial release
// ============================================================================
module layer_mac_sequencer #(
    parameter int N_INPUTS   = 4,
    parameter int N_NEURONS  = 3,
    parameter int IDX_W      = 8,
    parameter int CONTINUOUS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             ack_i,
    input  logic             mac_ready_i,
    output logic             ack_mac_o,
    output logic             busy_o,
    output logic [IDX_W-1:0] in_idx_o,
    output logic [IDX_W-1:0] neuron_idx_o,
    output logic             layer_done_o,
    output logic             ack_drop_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FIRE  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(N_INPUTS - 1);
    localparam logic [IDX_W-1:0] NEU_LAST = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] in_idx_q, in_idx_d;
    logic [IDX_W-1:0] neuron_idx_q, neuron_idx_d;
    logic             ack_mac_q, busy_q, layer_done_q, ack_drop_q;
    logic             ack_drop_d;

    always_comb begin
        state_d      = state_q;
        in_idx_d     = in_idx_q;
        neuron_idx_d = neuron_idx_q;
        // Acks are only reported as dropped once a pass is underway.
        ack_drop_d   = ack_i && ((state_q == S_FIRE) || (state_q == S_DONE));
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_ACCUM;
                    in_idx_d     = '0;
                    neuron_idx_d = '0;
                end
            end
            S_ACCUM: begin
                if (ack_i) begin
                    if (in_idx_q == IN_LAST) begin
                        state_d  = S_FIRE;
                        in_idx_d = '0;
                    end else begin
                        in_idx_d = in_idx_q + IDX_ONE;
                    end
                end
            end
            S_FIRE: begin
                if (mac_ready_i) begin
                    if (neuron_idx_q == NEU_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_ACCUM;
                        neuron_idx_d = neuron_idx_q + IDX_ONE;
                    end
                end
            end
            S_DONE: begin
                if (CONTINUOUS != 0) begin
                    state_d      = S_ACCUM;
                    neuron_idx_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            in_idx_q     <= '0;
            neuron_idx_q <= '0;
            ack_mac_q    <= 1'b0;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
            ack_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_idx_q     <= in_idx_d;
            neuron_idx_q <= neuron_idx_d;
            ack_mac_q    <= (state_d == S_FIRE);
            busy_q       <= (state_d != S_IDLE);
            layer_done_q <= (state_d == S_DONE);
            ack_drop_q   <= ack_drop_d;
        end
    end

    assign ack_mac_o    = ack_mac_q;
    assign busy_o       = busy_q;
    assign in_idx_o     = in_idx_q;
    assign neuron_idx_o = neuron_idx_q;
    assign layer_done_o = layer_done_q;
    assign ack_drop_o   = ack_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_mac_sequencer
// Brief    : Directed self-checking bench for layer_mac_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_mac_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: 4 inputs, 3 neurons, single pass
    logic       start_a = 0, ack_a = 0, rdy_a = 0;
    logic       ack_mac_a, busy_a, done_a, drop_a;
    logic [7:0] in_idx_a, nidx_a;
    // Instance B: 1 input, 1 neuron, single pass
    logic       start_b = 0, ack_b = 0, rdy_b = 0;
    logic       ack_mac_b, busy_b, done_b, drop_b;
    logic [7:0] in_idx_b, nidx_b;
    // Instance C: 2 inputs, 2 neurons, continuous
    logic       start_c = 0, ack_c = 0, rdy_c = 0;
    logic       ack_mac_c, busy_c, done_c, drop_c;
    logic [7:0] in_idx_c, nidx_c;

    layer_mac_sequencer #(.N_INPUTS(4), .N_NEURONS(3), .IDX_W(8), .CONTINUOUS(0)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .ack_i(ack_a), .mac_ready_i(rdy_a),
        .ack_mac_o(ack_mac_a), .busy_o(busy_a), .in_idx_o(in_idx_a),
        .neuron_idx_o(nidx_a), .layer_done_o(done_a), .ack_drop_o(drop_a));

    layer_mac_sequencer #(.N_INPUTS(1), .N_NEURONS(1), .IDX_W(8), .CONTINUOUS(0)) u_dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .ack_i(ack_b), .mac_ready_i(rdy_b),
        .ack_mac_o(ack_mac_b), .busy_o(busy_b), .in_idx_o(in_idx_b),
        .neuron_idx_o(nidx_b), .layer_done_o(done_b), .ack_drop_o(drop_b));

    layer_mac_sequencer #(.N_INPUTS(2), .N_NEURONS(2), .IDX_W(8), .CONTINUOUS(1)) u_dut_c (
        .clk(clk), .rst(rst), .start_i(start_c), .ack_i(ack_c), .mac_ready_i(rdy_c),
        .ack_mac_o(ack_mac_c), .busy_o(busy_c), .in_idx_o(in_idx_c),
        .neuron_idx_o(nidx_c), .layer_done_o(done_c), .ack_drop_o(drop_c));

    // Outputs are observed 1 time unit after the rising edge they reflect.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start_a = 0; ack_a = 0; rdy_a = 0;
        start_b = 0; ack_b = 0; rdy_b = 0;
        start_c = 0; ack_c = 0; rdy_c = 0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({ack_mac_a, busy_a, done_a, drop_a} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags_a: got %b want 0000", {ack_mac_a, busy_a, done_a, drop_a});
        end
        checks++;
        if ({in_idx_a, nidx_a} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_idx_a: got in=%0d n=%0d want 0/0", in_idx_a, nidx_a);
        end
        checks++;
        if ({ack_mac_b, busy_b, done_b, drop_b, ack_mac_c, busy_c, done_c, drop_c} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags_bc: got %b want 00000000",
                     {ack_mac_b, busy_b, done_b, drop_b, ack_mac_c, busy_c, done_c, drop_c});
        end
        // ack in IDLE is ignored and not reported as dropped
        rst = 1'b1;
        ack_a = 1;
        tick();
        ack_a = 0;
        checks++;
        if ({busy_a, drop_a, in_idx_a} !== {2'b00, 8'd0}) begin
            failures++;
            $display("FAIL idle_ack: got busy=%b drop=%b in=%0d want 0 0 0", busy_a, drop_a, in_idx_a);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        start_a = 1;
        tick();
        start_a = 0;
        checks++;
        if (busy_a !== 1'b1 || in_idx_a !== 8'd0) begin
            failures++;
            $display("FAIL nom_start: got busy=%b in=%0d want 1 0", busy_a, in_idx_a);
        end
        ack_a = 1; rdy_a = 1;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if (ack_mac_a !== (i == 3) || in_idx_a !== ((i == 3) ? 8'd0 : 8'(i + 1)) ||
                    nidx_a !== 8'(n)) begin
                    failures++;
                    $display("FAIL nom_accum n=%0d i=%0d: got mac=%b in=%0d nidx=%0d want mac=%b",
                             n, i, ack_mac_a, in_idx_a, nidx_a, (i == 3));
                end
            end
            tick();
            checks++;
            if (ack_mac_a !== 1'b0 || drop_a !== 1'b1 || done_a !== (n == 2) ||
                nidx_a !== ((n == 2) ? 8'd2 : 8'(n + 1))) begin
                failures++;
                $display("FAIL nom_fire n=%0d: got mac=%b drop=%b done=%b nidx=%0d",
                         n, ack_mac_a, drop_a, done_a, nidx_a);
            end
        end
        ack_a = 0;
        tick();
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || drop_a !== 1'b0) begin
            failures++;
            $display("FAIL nom_end: got done=%b busy=%b drop=%b want 0 0 0", done_a, busy_a, drop_a);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        start_a = 1;
        tick();
        start_a = 0;
        ack_a = 1; rdy_a = 0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 6; i++) begin
            ack_a = (i % 2 == 0);
            tick();
            checks++;
            if (ack_mac_a !== 1'b1 || in_idx_a !== 8'd0 || drop_a !== (i % 2 == 0) || nidx_a !== 8'd0) begin
                failures++;
                $display("FAIL bp_hold i=%0d: got mac=%b in=%0d drop=%b nidx=%0d",
                         i, ack_mac_a, in_idx_a, drop_a, nidx_a);
            end
        end
        ack_a = 0; rdy_a = 1;
        tick();
        checks++;
        if (ack_mac_a !== 1'b0 || nidx_a !== 8'd1 || busy_a !== 1'b1 || drop_a !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: got mac=%b nidx=%0d busy=%b drop=%b want 0 1 1 0",
                     ack_mac_a, nidx_a, busy_a, drop_a);
        end
        // Reset while firing must cancel the pending request
        ack_a = 1; rdy_a = 0;
        for (int i = 0; i < 4; i++) tick();
        ack_a = 0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (ack_mac_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL bp_fire_reset: got mac=%b busy=%b want 0 0", ack_mac_a, busy_a);
        end
    endtask

    task automatic test_sparse();
        do_reset();
        start_a = 1;
        tick();
        start_a = 0;
        for (int j = 0; j < 4; j++) begin
            ack_a = 1;
            tick();
            ack_a = 0;
            checks++;
            if (in_idx_a !== ((j == 3) ? 8'd0 : 8'(j + 1)) || ack_mac_a !== (j == 3)) begin
                failures++;
                $display("FAIL sparse_ack j=%0d: got in=%0d mac=%b", j, in_idx_a, ack_mac_a);
            end
            if (j < 3) begin
                tick();
                tick();
                checks++;
                if (in_idx_a !== 8'(j + 1) || ack_mac_a !== 1'b0) begin
                    failures++;
                    $display("FAIL sparse_hold j=%0d: got in=%0d mac=%b", j, in_idx_a, ack_mac_a);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        start_a = 1;
        tick();
        start_a = 0;
        ack_a = 1; rdy_a = 1;
        for (int i = 0; i < 4; i++) tick();
        ack_a = 0;
        tick();
        ack_a = 1;
        tick();
        tick();
        ack_a = 0;
        checks++;
        if (in_idx_a !== 8'd2 || nidx_a !== 8'd1) begin
            failures++;
            $display("FAIL mid_setup: got in=%0d nidx=%0d want 2 1", in_idx_a, nidx_a);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if ({ack_mac_a, busy_a, done_a, drop_a, in_idx_a, nidx_a} !== 20'h0) begin
            failures++;
            $display("FAIL mid_reset: got mac=%b busy=%b done=%b drop=%b in=%0d nidx=%0d want all 0",
                     ack_mac_a, busy_a, done_a, drop_a, in_idx_a, nidx_a);
        end
        start_a = 1;
        tick();
        start_a = 0;
        checks++;
        if (busy_a !== 1'b1 || nidx_a !== 8'd0 || in_idx_a !== 8'd0) begin
            failures++;
            $display("FAIL mid_restart: got busy=%b nidx=%0d in=%0d want 1 0 0", busy_a, nidx_a, in_idx_a);
        end
    endtask

    task automatic test_edge_params();
        do_reset();
        start_b = 1;
        tick();
        start_b = 0;
        ack_b = 1; rdy_b = 1;
        tick();
        ack_b = 0;
        start_b = 1;
        checks++;
        if (ack_mac_b !== 1'b1 || done_b !== 1'b0) begin
            failures++;
            $display("FAIL edge_fire: got mac=%b done=%b want 1 0", ack_mac_b, done_b);
        end
        tick();
        checks++;
        if (done_b !== 1'b1 || ack_mac_b !== 1'b0 || busy_b !== 1'b1) begin
            failures++;
            $display("FAIL edge_done: got done=%b mac=%b busy=%b want 1 0 1", done_b, ack_mac_b, busy_b);
        end
        tick();
        start_b = 0;
        checks++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin
            failures++;
            $display("FAIL edge_busy_start: got busy=%b done=%b want 0 0", busy_b, done_b);
        end
    endtask

    task automatic test_continuous();
        do_reset();
        start_c = 1;
        tick();
        start_c = 0;
        ack_c = 1; rdy_c = 1;
        for (int p = 0; p < 2; p++) begin
            for (int n = 0; n < 2; n++) begin
                tick();
                tick();
                checks++;
                if (ack_mac_c !== 1'b1 || nidx_c !== 8'(n)) begin
                    failures++;
                    $display("FAIL cont_fire p=%0d n=%0d: got mac=%b nidx=%0d", p, n, ack_mac_c, nidx_c);
                end
                tick();
                checks++;
                if (done_c !== (n == 1) || busy_c !== 1'b1) begin
                    failures++;
                    $display("FAIL cont_done p=%0d n=%0d: got done=%b busy=%b", p, n, done_c, busy_c);
                end
            end
            ack_c = 0;
            tick();
            ack_c = 1;
            checks++;
            if (done_c !== 1'b0 || busy_c !== 1'b1 || nidx_c !== 8'd0 || in_idx_c !== 8'd0) begin
                failures++;
                $display("FAIL cont_restart p=%0d: got done=%b busy=%b nidx=%0d in=%0d want 0 1 0 0",
                         p, done_c, busy_c, nidx_c, in_idx_c);
            end
        end
        ack_c = 0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_sparse();
        test_mid_reset();
        test_edge_params();
        test_continuous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
